// File: rtl/if_fetch_unit.sv
// Instruction fetch stage with a one-entry skid buffer and the IF/ID pipeline register.
// Redirects resolve in decode; the word fetched behind a taken redirect is squashed.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Stall,
   input  logic [1:0]  Jump,
   input  logic        Branch,
   input  logic        BranchCond,
   input  logic [31:0] JumpTarget,
   input  logic [31:0] RegTarget,
   input  logic        Exception,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] Instruction,
   output logic [31:0] PC,
   output logic        IFID_Valid
);

   // state   | meaning
   // S_FETCH | normal fetch; request whenever the skid buffer is empty
   // S_DROP  | a squashed request is still outstanding; hold its address, discard its data
   typedef enum logic [0:0] {S_FETCH, S_DROP} state_t;

   state_t      state, state_n;
   logic [31:0] fetch_pc, fetch_pc_n;
   logic [31:0] drop_addr, drop_addr_n;
   logic        buf_full, buf_full_n;
   logic [31:0] buf_data, buf_data_n;
   logic [31:0] buf_pc, buf_pc_n;
   logic [31:0] instr_n, pc_n;
   logic        valid_n;

   logic        redirect;
   logic        ack;
   logic [31:0] target_raw, target;
   logic [31:0] fetch_pc_inc;

   // Non-exception redirects wait for Stall to drop: decode operands are not final yet.
   assign redirect = Exception | (~Stall & ((Jump != 2'b00) | (Branch & BranchCond)));

   always_comb begin
      target_raw = JumpTarget;
      if (Exception)
         target_raw = EXC_VECTOR;
      else if (Jump == 2'b10)
         target_raw = RegTarget;
   end

   assign target       = target_raw & ~32'h0000_0003;
   assign fetch_pc_inc = fetch_pc + 32'd4;

   assign imem_req  = ~reset & ((state == S_DROP) | ~buf_full);
   assign imem_addr = (state == S_DROP) ? drop_addr : fetch_pc;
   assign ack       = imem_ack & imem_req;

   always_comb begin
      state_n     = state;
      fetch_pc_n  = fetch_pc;
      drop_addr_n = drop_addr;
      buf_full_n  = buf_full;
      buf_data_n  = buf_data;
      buf_pc_n    = buf_pc;
      instr_n     = Instruction;
      pc_n        = PC;
      valid_n     = IFID_Valid;

      if (redirect) begin
         fetch_pc_n = target;
         buf_full_n = 1'b0;
         instr_n    = 32'h0;
         valid_n    = 1'b0;
         pc_n       = target;
         if (state == S_FETCH) begin
            if (imem_req && !imem_ack) begin
               state_n     = S_DROP;
               drop_addr_n = fetch_pc;
            end
         end else begin
            state_n = ack ? S_FETCH : S_DROP;
         end
      end else if (state == S_DROP) begin
         if (ack)
            state_n = S_FETCH;
         if (!Stall) begin
            instr_n = 32'h0;
            valid_n = 1'b0;
         end
      end else if (Stall) begin
         if (ack) begin
            buf_full_n = 1'b1;
            buf_data_n = imem_rdata;
            buf_pc_n   = fetch_pc;
            fetch_pc_n = fetch_pc_inc;
         end
      end else begin
         if (buf_full) begin
            instr_n    = buf_data;
            pc_n       = buf_pc;
            valid_n    = 1'b1;
            buf_full_n = 1'b0;
            if (ack) begin
               buf_full_n = 1'b1;
               buf_data_n = imem_rdata;
               buf_pc_n   = fetch_pc;
               fetch_pc_n = fetch_pc_inc;
            end
         end else if (ack) begin
            instr_n    = imem_rdata;
            pc_n       = fetch_pc;
            valid_n    = 1'b1;
            fetch_pc_n = fetch_pc_inc;
         end else begin
            instr_n = 32'h0;
            valid_n = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_FETCH;
         fetch_pc    <= RESET_PC;
         drop_addr   <= 32'h0;
         buf_full    <= 1'b0;
         buf_data    <= 32'h0;
         buf_pc      <= 32'h0;
         Instruction <= 32'h0;
         PC          <= 32'h0;
         IFID_Valid  <= 1'b0;
      end else begin
         state       <= state_n;
         fetch_pc    <= fetch_pc_n;
         drop_addr   <= drop_addr_n;
         buf_full    <= buf_full_n;
         buf_data    <= buf_data_n;
         buf_pc      <= buf_pc_n;
         Instruction <= instr_n;
         PC          <= pc_n;
         IFID_Valid  <= valid_n;
      end
   end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction fetch stage and IF/ID pipeline register. It generates fetch addresses, runs a request/acknowledge handshake with instruction memory, and presents Instruction/PC/IFID_Valid to the decode stage. It consumes decode's redirect outputs (Jump, Branch, BranchCond, JumpTarget, jump-register value) and the hazard stall. Branches and jumps resolve in decode, and there is no delay slot: the instruction fetched behind a taken redirect is squashed.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded at reset
EXC_VECTOR, 32'h8000_0180, fetch address loaded on Exception

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
Stall  in  1  hazard unit: hold IF/ID contents and decode outputs this cycle
Jump  in  2  decode PCSrc: 00 sequential, 01 immediate jump (JumpTarget), 10 register jump (RegTarget), 11 treated as 01
Branch  in  1  decode holds a conditional branch
BranchCond  in  1  branch condition true
JumpTarget  in  32  jump/branch target from decode
RegTarget  in  32  forwarded rs value, used for jr/jalr
Exception  in  1  redirect to EXC_VECTOR; overrides Stall
imem_req  out  1  fetch request
imem_addr  out  32  fetch address, word aligned
imem_ack  in  1  memory response; imem_rdata is valid in the same cycle
imem_rdata  in  32  fetched word
Instruction  out  32  IF/ID instruction; 32'h0 when not valid
PC  out  32  IF/ID address of Instruction
IFID_Valid  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (synchronous, active-high; the codebase names the ports clk and reset): fetch_pc=RESET_PC; Instruction=0; PC=0; IFID_Valid=0; buffer empty; state=FETCH; imem_req=0 while reset is high.
- imem_addr=fetch_pc. Once imem_req is raised, it and imem_addr stay stable until imem_ack. imem_ack may arrive in the same cycle as the request (zero-wait ROM) or later.
- Redirect: Exception, or (!Stall and (Jump!=00 or (Branch and BranchCond))). Target priority: Exception gives EXC_VECTOR; else Jump==10 gives RegTarget; else Jump 01/11 gives JumpTarget; else branch taken gives JumpTarget. A non-exception redirect while Stall=1 is ignored, because decode operands are not final.
- Skid buffer: one 32-bit entry plus its address. It captures an acked word that cannot enter IF/ID because of Stall. While it is full, imem_req=0.
- State FETCH: imem_req=!buf_full.
  - Ack with no redirect and Stall=0: IF/ID loads buffer contents if the buffer is full (the acked word then goes into the buffer), otherwise loads the acked word directly. fetch_pc+=4.
  - Ack with Stall=1 and no redirect: word goes to the buffer and fetch_pc+=4. IF/ID holds.
  - Redirect: IF/ID loads a bubble (Instruction=0, IFID_Valid=0, PC=target). Buffer is cleared and fetch_pc=target. If a request is outstanding and not acked this cycle, go to DROP; otherwise stay in FETCH.
- State DROP: imem_req=1 with the old address held. On ack, discard the data and go to FETCH; fetch_pc already holds the target. A new redirect in DROP overwrites fetch_pc and the state stays DROP. IF/ID loads a bubble whenever Stall=0.
- Stall=0 with nothing available to deliver: IF/ID loads a bubble.
- Stall=1 and no Exception: Instruction, PC and IFID_Valid hold their values.
- Latency: a zero-wait ROM gives sustained one instruction per cycle. A redirect decided in cycle N puts the target address on imem_addr in cycle N+1, and the target instruction is in IF/ID at N+2 on a zero-wait ack.
- fetch_pc+4 wraps modulo 2^32. Bits [1:0] of any target are forced to 00.
- Exception takes priority over Stall, branch, jump and the buffer, and behaves like a redirect in every state.

Test Plan:
- Reset, then zero-wait ROM with imem_ack=1 holding word(addr)=addr. Expect imem_addr 0,4,8 on consecutive cycles; IF/ID PC 0,4,8 one cycle later; IFID_Valid=1 from the second cycle after reset release.
- Branch=1, BranchCond=1, JumpTarget=0x40 while ID holds PC=0x8. Expect the next IF/ID to be a bubble (Instruction=0, Valid=0) and the following IF/ID to be PC=0x40. Then repeat with BranchCond=0 and expect sequential 0xC.
- Jump=10, RegTarget=0x1003. Expect imem_addr=0x1000 the next cycle.
- Stall held 3 cycles during ack of 0x10. Expect IF/ID frozen, the buffer to hold 0x10, and imem_req=0. After release, IF/ID takes 0x10 then 0x14 with no loss or duplicate.
- Ack latency 3 cycles, and Jump=01 to 0x200 in the cycle after the request to 0x20. Expect imem_addr to stay 0x20 until ack, that data to be discarded, and the next request to go to 0x200.
- Exception=1 with Stall=1 while in DROP. Expect IF/ID to become a bubble, and the first request after the outstanding ack to be 0x8000_0180.
